// File: rtl/f_fetch_queue_if.sv
// Fetch-queue bus: fetch-side push inputs, the PCWE throttle, flush, and the
// decode-side head/handshake.
// Optional feature macro: FQ_EXC_EN adds the D_ExcCode head field.
// Handshake: the head entry transfers when D_valid & D_ready are both high at
// a rising clock edge; the fetch side pushes whenever F_PCWE is high and flush
// is low.
// Modport master is the queue itself; slave is the fetch/decode environment.
interface f_fetch_queue_if #(
  parameter int AW = 2
);
  logic [31:0] F_PC;
  logic [31:0] F_Instr;
  logic        F_PCWE;
  logic        flush;
  logic        D_ready;
  logic        D_valid;
  logic [31:0] D_PC;
  logic [31:0] D_Instr;
  logic [AW:0] fq_count;
`ifdef FQ_EXC_EN
  logic [4:0]  D_ExcCode;

  modport master (
    input  F_PC, F_Instr, flush, D_ready,
    output F_PCWE, D_valid, D_PC, D_Instr, fq_count, D_ExcCode
  );
  modport slave (
    output F_PC, F_Instr, flush, D_ready,
    input  F_PCWE, D_valid, D_PC, D_Instr, fq_count, D_ExcCode
  );
`else
  modport master (
    input  F_PC, F_Instr, flush, D_ready,
    output F_PCWE, D_valid, D_PC, D_Instr, fq_count
  );
  modport slave (
    output F_PC, F_Instr, flush, D_ready,
    input  F_PCWE, D_valid, D_PC, D_Instr, fq_count
  );
`endif
endinterface

// File: rtl/f_fetch_queue.sv
// Instruction fetch queue between the fetch unit and decode.
// Captures one {PC, Instr} pair per cycle while F_PCWE is high, presents the
// oldest entry to decode, and clears itself on a branch/jump flush.
// Optional feature macro: FQ_EXC_EN records an AdEL exception code per entry
// for misaligned or out-of-range fetch addresses.
module f_fetch_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          reset,
  f_fetch_queue_if.master bus
);
  localparam logic [AW:0] L_DEPTH = (AW+1)'(DEPTH);

  logic [31:0]   r_pc    [DEPTH];
  logic [31:0]   r_instr [DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [AW:0]   r_count;

  logic          w_valid;
  logic          w_pop;
  logic          w_pcwe;
  logic          w_push;
  logic [31:0]   w_instr_in;

`ifdef FQ_EXC_EN
  logic [4:0]    r_exc [DEPTH];
  logic          w_bad_addr;
  logic [4:0]    w_exc_in;

  // Instruction fetch address error: misaligned or outside the program region.
  assign w_bad_addr = (bus.F_PC[1:0] != 2'b00) ||
                      (bus.F_PC < 32'h0000_3000) ||
                      (bus.F_PC > 32'h0000_6FFC);
  assign w_exc_in   = w_bad_addr ? 5'd4 : 5'd0;
  // A faulting fetch is stored as a nop so decode never acts on garbage.
  assign w_instr_in = w_bad_addr ? 32'h0 : bus.F_Instr;
`else
  assign w_instr_in = bus.F_Instr;
`endif

  assign w_valid = (r_count != '0);
  assign w_pop   = w_valid & bus.D_ready;
  // A full queue can still accept a push in the same cycle it pops.
  assign w_pcwe  = (r_count != L_DEPTH) | w_pop;
  // Flush drops the push but leaves PCWE alone so the redirect PC loads.
  assign w_push  = w_pcwe & ~bus.flush;

  assign bus.F_PCWE   = w_pcwe;
  assign bus.D_valid  = w_valid;
  assign bus.fq_count = r_count;

  // Head outputs read as a nop whenever the queue is empty.
  always_comb begin
    bus.D_PC    = 32'h0;
    bus.D_Instr = 32'h0;
`ifdef FQ_EXC_EN
    bus.D_ExcCode = 5'd0;
`endif
    if (w_valid) begin
      bus.D_PC    = r_pc[r_rd_ptr];
      bus.D_Instr = r_instr[r_rd_ptr];
`ifdef FQ_EXC_EN
      bus.D_ExcCode = r_exc[r_rd_ptr];
`endif
    end
  end

  // Entry storage: cleared on reset, written at the tail on each push.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_pc[i]    <= 32'h0;
        r_instr[i] <= 32'h0;
`ifdef FQ_EXC_EN
        r_exc[i]   <= 5'd0;
`endif
      end
    end else if (w_push) begin
      r_pc[r_wr_ptr]    <= bus.F_PC;
      r_instr[r_wr_ptr] <= w_instr_in;
`ifdef FQ_EXC_EN
      r_exc[r_wr_ptr]   <= w_exc_in;
`endif
    end
  end

  // Pointers and occupancy: reset, then flush, then normal push/pop.
  always_ff @(posedge clk) begin
    if (reset || bus.flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
